bus_arbiter: RTL and testbench

- Round-robin arbiter sharing the single multiplexed address/data system bus between up to NUM_MASTERS bus masters (memory stage, instruction fetch, DMA, …).
- Consumes each master's requestBus and returns a one-hot busAccessGranted.
- Monitors beginTransactionIn/endTransactionIn to hold a grant for a full transaction.
- Revokes stale grants and aborts hung transactions with a bus error.

---
 rtl/bus_arbiter_pkg.sv | 28 ++
 rtl/bus_arbiter_if.sv | 38 +++
 rtl/bus_arbiter_rr_priority_select.sv | 43 ++++
 rtl/bus_arbiter.sv | 165 ++++++++++++++++
 tb/tb_bus_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_arbiter_pkg
// Shared types and constants for the system-bus round-robin arbiter.
//   state_t                     : arbiter FSM encoding (IDLE/GRANTED/BUSY/RELEASE)
//   IDX_W                       : width of the activeMaster index
//   DEFAULT_GRANT_TIMEOUT       : cycles a grant may sit unused
//   DEFAULT_TRANSACTION_TIMEOUT : cycles a transaction may run (watchdog build)
//   cnt_width()                 : counter width able to hold values up to n-1
// -----------------------------------------------------------------------------
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        BUSY    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam int unsigned IDX_W                       = 4;
    localparam int unsigned DEFAULT_GRANT_TIMEOUT       = 16;
    localparam int unsigned DEFAULT_TRANSACTION_TIMEOUT = 256;

    // Bits needed to count 0 .. n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : bus_arbiter_pkg

// File: rtl/bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// bus_arbiter_if
// Arbitration signals between the bus masters/slave and the arbiter.
//   requests           : per-master requestBus (level)
//   beginTransactionIn : wired-OR begin strobe
//   endTransactionIn   : end strobe from the addressed slave
//   busErrorIn         : slave-signalled error
//   grants             : one-hot busAccessGranted
//   activeMaster       : index of the granted master, 0 when idle
//   busErrorOut        : arbiter-generated error pulse
//   busIdle            : no grant and arbiter idle
// Modports: slave (arbiter side), master (requester/bus side).
// -----------------------------------------------------------------------------
interface bus_arbiter_if #(
    parameter int unsigned NUM_MASTERS = 4
);
    import bus_arbiter_pkg::*;

    logic [NUM_MASTERS-1:0] requests;
    logic                   beginTransactionIn;
    logic                   endTransactionIn;
    logic                   busErrorIn;
    logic [NUM_MASTERS-1:0] grants;
    logic [IDX_W-1:0]       activeMaster;
    logic                   busErrorOut;
    logic                   busIdle;

    modport slave (
        input  requests, beginTransactionIn, endTransactionIn, busErrorIn,
        output grants, activeMaster, busErrorOut, busIdle
    );

    modport master (
        output requests, beginTransactionIn, endTransactionIn, busErrorIn,
        input  grants, activeMaster, busErrorOut, busIdle
    );

endinterface : bus_arbiter_if

// File: rtl/bus_arbiter_rr_priority_select.sv
// -----------------------------------------------------------------------------
// rr_priority_select
// Combinational rotate-and-find-first: picks the first asserted request at or
// after i_pointer, wrapping modulo NUM_MASTERS.
//   i_requests : request vector
//   i_pointer  : starting slot (must be < NUM_MASTERS)
//   o_valid    : at least one request asserted
//   o_onehot   : one-hot winner (0 when none)
//   o_index    : winner index (0 when none)
// -----------------------------------------------------------------------------
module rr_priority_select #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned IDX_W       = 4
) (
    input  logic [NUM_MASTERS-1:0] i_requests,
    input  logic [IDX_W-1:0]       i_pointer,
    output logic                   o_valid,
    output logic [NUM_MASTERS-1:0] o_onehot,
    output logic [IDX_W-1:0]       o_index
);

    logic [IDX_W-1:0]       w_slot;
    logic [NUM_MASTERS-1:0] w_shifted;

    // Scan slots in rotated order; the first hit wins.
    always_comb begin
        o_valid   = 1'b0;
        o_onehot  = '0;
        o_index   = '0;
        w_slot    = '0;
        w_shifted = '0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            w_slot    = IDX_W'((32'(i_pointer) + k) % NUM_MASTERS);
            w_shifted = i_requests >> w_slot;
            if (!o_valid && w_shifted[0]) begin
                o_valid  = 1'b1;
                o_index  = w_slot;
                o_onehot = NUM_MASTERS'(1) << w_slot;
            end
        end
    end

endmodule : rr_priority_select

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Round-robin arbiter for the shared multiplexed address/data system bus.
// Holds a grant for a whole transaction (begin..end), revokes grants that go
// unused for GRANT_TIMEOUT cycles and inserts one RELEASE turnaround cycle
// after every grant.
//   clock : system clock
//   reset : asynchronous active-low reset
//   bus   : bus_arbiter_if.slave (requests/strobes in, grants/status out)
// Optional build macro BUS_ARBITER_WATCHDOG_EN: aborts a transaction still
// open after TRANSACTION_TIMEOUT cycles with a one-cycle busErrorOut pulse
// (TRANSACTION_TIMEOUT must be >= 2). Without it busErrorOut stays 0.
// -----------------------------------------------------------------------------
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MASTERS         = 4,
    parameter int unsigned GRANT_TIMEOUT       = DEFAULT_GRANT_TIMEOUT,
    parameter int unsigned TRANSACTION_TIMEOUT = DEFAULT_TRANSACTION_TIMEOUT
) (
    input  logic         clock,
    input  logic         reset,
    bus_arbiter_if.slave bus
);

    localparam int unsigned CNT_MAX = (GRANT_TIMEOUT > TRANSACTION_TIMEOUT) ?
                                      GRANT_TIMEOUT : TRANSACTION_TIMEOUT;
    localparam int unsigned CNT_W   = cnt_width(CNT_MAX);

    state_t                 r_state,      w_state_next;
    logic [CNT_W-1:0]       r_cnt,        w_cnt_next;
    logic [NUM_MASTERS-1:0] r_grants,     w_grants_next;
    logic [IDX_W-1:0]       r_active,     w_active_next;
    logic [IDX_W-1:0]       r_rr_ptr,     w_rr_ptr_next;
    logic                   r_bus_err,    w_bus_err_next;
    logic                   r_bus_idle,   w_bus_idle_next;

    logic                   w_sel_valid;
    logic [NUM_MASTERS-1:0] w_sel_onehot;
    logic [IDX_W-1:0]       w_sel_index;
    logic                   w_req_granted;

    rr_priority_select #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_rr_select (
        .i_requests  (bus.requests),
        .i_pointer   (r_rr_ptr),
        .o_valid     (w_sel_valid),
        .o_onehot    (w_sel_onehot),
        .o_index     (w_sel_index)
    );

    // Request line of the master currently holding the grant.
    assign w_req_granted = |(bus.requests & r_grants);

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_grants   <= '0;
            r_active   <= '0;
            r_rr_ptr   <= '0;
            r_bus_err  <= 1'b0;
            r_bus_idle <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_grants   <= w_grants_next;
            r_active   <= w_active_next;
            r_rr_ptr   <= w_rr_ptr_next;
            r_bus_err  <= w_bus_err_next;
            r_bus_idle <= w_bus_idle_next;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_grants_next   = r_grants;
        w_active_next   = r_active;
        w_rr_ptr_next   = r_rr_ptr;
        w_bus_err_next  = 1'b0;

        case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                if (w_sel_valid) begin
                    w_state_next  = GRANTED;
                    w_grants_next = w_sel_onehot;
                    w_active_next = w_sel_index;
                    w_rr_ptr_next = (w_sel_index == IDX_W'(NUM_MASTERS - 1)) ?
                                    '0 : w_sel_index + IDX_W'(1);
                end
            end

            GRANTED: begin
                if (bus.beginTransactionIn) begin
                    // Begin wins over drop/timeout; begin+end is a single beat.
                    w_cnt_next = '0;
                    if (bus.endTransactionIn) begin
                        w_state_next  = RELEASE;
                        w_grants_next = '0;
                        w_active_next = '0;
                    end else begin
                        w_state_next = BUSY;
                    end
                end else if (!w_req_granted ||
                             (r_cnt == CNT_W'(GRANT_TIMEOUT - 1))) begin
                    w_state_next  = RELEASE;
                    w_grants_next = '0;
                    w_active_next = '0;
                end else if (r_cnt != '1) begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end

            BUSY: begin
                if (bus.endTransactionIn || bus.busErrorIn) begin
                    w_state_next  = RELEASE;
                    w_grants_next = '0;
                    w_active_next = '0;
                end
`ifdef BUS_ARBITER_WATCHDOG_EN
                else if (r_cnt == CNT_W'(TRANSACTION_TIMEOUT - 1)) begin
                    w_state_next  = RELEASE;
                    w_grants_next = '0;
                    w_active_next = '0;
                end else begin
                    // Pulse is pre-registered so it lines up with the last
                    // granted cycle of the aborted transaction.
                    if (r_cnt == CNT_W'(TRANSACTION_TIMEOUT - 2)) begin
                        w_bus_err_next = 1'b1;
                    end
                    if (r_cnt != '1) begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
`endif
            end

            RELEASE: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end

            default: begin
                w_state_next  = IDLE;
                w_cnt_next    = '0;
                w_grants_next = '0;
                w_active_next = '0;
            end
        endcase

        w_bus_idle_next = (w_state_next == IDLE);
    end

    assign bus.grants       = r_grants;
    assign bus.activeMaster = r_active;
    assign bus.busErrorOut  = r_bus_err;
    assign bus.busIdle      = r_bus_idle;

endmodule : bus_arbiter

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Directed self-checking bench for bus_arbiter (NUM_MASTERS=4,
// GRANT_TIMEOUT=16, TRANSACTION_TIMEOUT=8). Cycle k is the interval just after
// the k-th rising edge following stimulus; inputs change and outputs are
// sampled 1 time unit after the edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bus_arbiter;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_fail;

    bus_arbiter_if #(.NUM_MASTERS(4)) bus ();

    bus_arbiter #(
        .NUM_MASTERS         (4),
        .GRANT_TIMEOUT       (16),
        .TRANSACTION_TIMEOUT (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        bus.requests           = 4'b0000;
        bus.beginTransactionIn = 1'b0;
        bus.endTransactionIn   = 1'b0;
        bus.busErrorIn         = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (bus.grants !== 4'b0000) begin n_fail++; $display("FAIL reset_grants: got %b expected 0000", bus.grants); end
        n_cmp++; if (bus.activeMaster !== 4'd0) begin n_fail++; $display("FAIL reset_active: got %0d expected 0", bus.activeMaster); end
        n_cmp++; if (bus.busErrorOut !== 1'b0) begin n_fail++; $display("FAIL reset_buserr: got %b expected 0", bus.busErrorOut); end
        n_cmp++; if (bus.busIdle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b expected 1", bus.busIdle); end
        // Begin strobe while idle must not grant anything.
        bus.beginTransactionIn = 1'b1;
        tick();
        bus.beginTransactionIn = 1'b0;
        tick();
        n_cmp++; if (bus.grants !== 4'b0000 || bus.busIdle !== 1'b1) begin n_fail++; $display("FAIL idle_begin_ignored: got grants=%b idle=%b expected 0000/1", bus.grants, bus.busIdle); end
    endtask

    task automatic test_single_request();
        apply_reset();
        bus.requests = 4'b0100;            // cycle 0
        tick();                            // cycle 1
        n_cmp++; if (bus.grants !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b expected 0100", bus.grants); end
        n_cmp++; if (bus.activeMaster !== 4'd2) begin n_fail++; $display("FAIL single_active: got %0d expected 2", bus.activeMaster); end
        n_cmp++; if (bus.busIdle !== 1'b0) begin n_fail++; $display("FAIL single_idle_low: got %b expected 0", bus.busIdle); end
        tick();                            // cycle 2
        tick();                            // cycle 3
        bus.beginTransactionIn = 1'b1;
        tick();                            // cycle 4 (BUSY)
        bus.beginTransactionIn = 1'b0;
        tick();                            // cycle 5
        tick();                            // cycle 6
        n_cmp++; if (bus.grants !== 4'b0100) begin n_fail++; $display("FAIL single_held: got %b expected 0100", bus.grants); end
        bus.endTransactionIn = 1'b1;
        bus.requests         = 4'b0000;
        tick();                            // cycle 7 (RELEASE)
        bus.endTransactionIn = 1'b0;
        n_cmp++; if (bus.grants !== 4'b0000 || bus.busIdle !== 1'b0) begin n_fail++; $display("FAIL single_release: got grants=%b idle=%b expected 0000/0", bus.grants, bus.busIdle); end
        tick();                            // cycle 8 (IDLE)
        n_cmp++; if (bus.busIdle !== 1'b1 || bus.activeMaster !== 4'd0) begin n_fail++; $display("FAIL single_idle: got idle=%b active=%0d expected 1/0", bus.busIdle, bus.activeMaster); end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_g;
        apply_reset();
        bus.requests = 4'b1111;
        tick();
        for (int g = 0; g < 5; g++) begin
            exp_g = 4'b0001 << (g % 4);
            n_cmp++; if (bus.grants !== exp_g || bus.activeMaster !== 4'(g % 4)) begin n_fail++; $display("FAIL fair_grant_%0d: got %b/%0d expected %b/%0d", g, bus.grants, bus.activeMaster, exp_g, g % 4); end
            bus.beginTransactionIn = 1'b1;
            tick();
            bus.beginTransactionIn = 1'b0;
            tick();
            bus.endTransactionIn = 1'b1;
            tick();                        // RELEASE
            bus.endTransactionIn = 1'b0;
            n_cmp++; if (bus.grants !== 4'b0000 || bus.busIdle !== 1'b0) begin n_fail++; $display("FAIL fair_release_%0d: got %b/%b expected 0000/0", g, bus.grants, bus.busIdle); end
            tick();                        // IDLE
            n_cmp++; if (bus.grants !== 4'b0000 || bus.busIdle !== 1'b1) begin n_fail++; $display("FAIL fair_idle_%0d: got %b/%b expected 0000/1", g, bus.grants, bus.busIdle); end
            tick();
        end
        bus.requests = 4'b0000;
    endtask

    task automatic test_grant_timeout();
        int held;
        int errs;
        held = 0;
        errs = 0;
        apply_reset();
        bus.requests = 4'b0110;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (bus.grants === 4'b0010) held++;
            if (bus.busErrorOut !== 1'b0) errs++;
        end
        n_cmp++; if (held !== 16) begin n_fail++; $display("FAIL timeout_held: got %0d cycles expected 16", held); end
        tick();                            // cycle 17
        n_cmp++; if (bus.grants !== 4'b0000 || bus.busErrorOut !== 1'b0) begin n_fail++; $display("FAIL timeout_revoke: got %b err=%b expected 0000/0", bus.grants, bus.busErrorOut); end
        n_cmp++; if (errs !== 0) begin n_fail++; $display("FAIL timeout_no_err: got %0d err cycles expected 0", errs); end
        tick();                            // cycle 18
        n_cmp++; if (bus.grants !== 4'b0000) begin n_fail++; $display("FAIL timeout_gap: got %b expected 0000", bus.grants); end
        tick();                            // cycle 19
        n_cmp++; if (bus.grants !== 4'b0100 || bus.activeMaster !== 4'd2) begin n_fail++; $display("FAIL timeout_next: got %b/%0d expected 0100/2", bus.grants, bus.activeMaster); end
        bus.requests = 4'b0000;
    endtask

    task automatic test_request_drop();
        apply_reset();
        bus.requests = 4'b0001;
        tick();
        n_cmp++; if (bus.grants !== 4'b0001) begin n_fail++; $display("FAIL drop_grant: got %b expected 0001", bus.grants); end
        bus.requests = 4'b0000;
        tick();
        n_cmp++; if (bus.grants !== 4'b0000 || bus.busIdle !== 1'b0) begin n_fail++; $display("FAIL drop_release: got %b/%b expected 0000/0", bus.grants, bus.busIdle); end
        tick();
    endtask

    task automatic test_single_beat();
        apply_reset();
        bus.requests = 4'b1000;
        tick();
        n_cmp++; if (bus.grants !== 4'b1000 || bus.activeMaster !== 4'd3) begin n_fail++; $display("FAIL beat_grant: got %b/%0d expected 1000/3", bus.grants, bus.activeMaster); end
        bus.beginTransactionIn = 1'b1;
        bus.endTransactionIn   = 1'b1;
        bus.requests           = 4'b0000;
        tick();
        bus.beginTransactionIn = 1'b0;
        bus.endTransactionIn   = 1'b0;
        n_cmp++; if (bus.grants !== 4'b0000 || bus.busIdle !== 1'b0) begin n_fail++; $display("FAIL beat_release: got %b/%b expected 0000/0", bus.grants, bus.busIdle); end
        // Pointer wrapped after master 3, so master 0 beats master 3.
        bus.requests = 4'b1001;
        tick();
        n_cmp++; if (bus.busIdle !== 1'b1) begin n_fail++; $display("FAIL beat_idle: got %b expected 1", bus.busIdle); end
        tick();
        n_cmp++; if (bus.grants !== 4'b0001 || bus.activeMaster !== 4'd0) begin n_fail++; $display("FAIL beat_wrap: got %b/%0d expected 0001/0", bus.grants, bus.activeMaster); end
        bus.requests = 4'b0000;
    endtask

    task automatic test_busy_error();
        apply_reset();
        bus.requests = 4'b0001;
        tick();
        bus.beginTransactionIn = 1'b1;
        tick();
        bus.beginTransactionIn = 1'b0;
        bus.requests = 4'b0000;            // ignored while BUSY
        tick();
        tick();
        n_cmp++; if (bus.grants !== 4'b0001) begin n_fail++; $display("FAIL busy_hold: got %b expected 0001", bus.grants); end
        bus.busErrorIn = 1'b1;
        tick();
        bus.busErrorIn = 1'b0;
        n_cmp++; if (bus.grants !== 4'b0000 || bus.busErrorOut !== 1'b0) begin n_fail++; $display("FAIL busy_slave_err: got %b/%b expected 0000/0", bus.grants, bus.busErrorOut); end
        tick();
    endtask

`ifdef BUS_ARBITER_WATCHDOG_EN
    task automatic test_watchdog();
        apply_reset();
        bus.requests = 4'b0001;
        tick();
        bus.beginTransactionIn = 1'b1;
        tick();                            // BUSY cycle 1
        bus.beginTransactionIn = 1'b0;
        for (int c = 2; c <= 7; c++) tick();
        n_cmp++; if (bus.busErrorOut !== 1'b0 || bus.grants !== 4'b0001) begin n_fail++; $display("FAIL wd_cycle7: got err=%b g=%b expected 0/0001", bus.busErrorOut, bus.grants); end
        tick();                            // BUSY cycle 8
        n_cmp++; if (bus.busErrorOut !== 1'b1 || bus.grants !== 4'b0001) begin n_fail++; $display("FAIL wd_pulse: got err=%b g=%b expected 1/0001", bus.busErrorOut, bus.grants); end
        bus.requests = 4'b0000;
        tick();
        n_cmp++; if (bus.busErrorOut !== 1'b0 || bus.grants !== 4'b0000) begin n_fail++; $display("FAIL wd_abort: got err=%b g=%b expected 0/0000", bus.busErrorOut, bus.grants); end
        tick();
    endtask
`else
    task automatic test_watchdog();
        int held;
        held = 0;
        apply_reset();
        bus.requests = 4'b0001;
        tick();
        bus.beginTransactionIn = 1'b1;
        tick();
        bus.beginTransactionIn = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (bus.grants === 4'b0001 && bus.busErrorOut === 1'b0) held++;
            tick();
        end
        n_cmp++; if (held !== 1000) begin n_fail++; $display("FAIL nowd_hold: got %0d cycles expected 1000", held); end
        bus.endTransactionIn = 1'b1;
        bus.requests = 4'b0000;
        tick();
        bus.endTransactionIn = 1'b0;
        n_cmp++; if (bus.grants !== 4'b0000) begin n_fail++; $display("FAIL nowd_end: got %b expected 0000", bus.grants); end
        tick();
    endtask
`endif

    task automatic test_async_reset();
        apply_reset();
        bus.requests = 4'b0100;
        tick();
        bus.beginTransactionIn = 1'b1;
        tick();
        bus.beginTransactionIn = 1'b0;
        tick();
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.grants !== 4'b0000 || bus.activeMaster !== 4'd0 || bus.busIdle !== 1'b1) begin n_fail++; $display("FAIL async_reset: got %b/%0d/%b expected 0000/0/1", bus.grants, bus.activeMaster, bus.busIdle); end
        bus.requests = 4'b0000;
        tick();
        reset = 1'b1;
        // Pointer back at 0: master 0 must beat master 3.
        bus.requests = 4'b1001;
        tick();
        n_cmp++; if (bus.grants !== 4'b0001 || bus.activeMaster !== 4'd0) begin n_fail++; $display("FAIL async_regrant: got %b/%0d expected 0001/0", bus.grants, bus.activeMaster); end
        bus.requests = 4'b0000;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b0;
        bus.requests           = 4'b0000;
        bus.beginTransactionIn = 1'b0;
        bus.endTransactionIn   = 1'b0;
        bus.busErrorIn         = 1'b0;
        test_reset();
        test_single_request();
        test_fairness();
        test_grant_timeout();
        test_request_drop();
        test_single_beat();
        test_busy_error();
        test_watchdog();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_bus_arbiter
